// File: rtl/logic_unit.sv
// -----------------------------------------------------------------------------
// logic_unit
// Bitwise logic unit with a small in-order result buffer. Each accepted request
// computes one of eight bitwise operations on in0/in1 and queues the result and
// its all-zero flag. The consumer drains results in push order through a
// valid/ready handshake.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : synchronous active-high reset
//   in_valid   : request present on in0/in1/op
//   in_ready   : request accepted this cycle (buffer not full)
//   in0, in1   : operands A and B, WIDTH bits
//   op         : operation select (AND, OR, XOR, NOR, NAND, XNOR, ANDN, ORN)
//   out_valid  : out/zero hold a result (buffer not empty)
//   out_ready  : consumer takes the head result this cycle
//   out        : head result, WIDTH bits
//   zero       : head result is all zeros
//   count      : number of occupied buffer entries
// -----------------------------------------------------------------------------
module logic_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in0,
    input  logic [WIDTH-1:0]        in1,
    input  logic [2:0]              op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out,
    output logic                    zero,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NOR  = 3'b011,
        OP_NAND = 3'b100,
        OP_XNOR = 3'b101,
        OP_ANDN = 3'b110,
        OP_ORN  = 3'b111
    } op_e;

    // Buffer storage: result plus its zero flag captured at push time
    logic [WIDTH-1:0] r_mem  [DEPTH];
    logic             r_zmem [DEPTH];

    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out;
    logic             r_zero;

    logic [WIDTH-1:0] w_res;
    logic             w_res_zero;
    logic             w_push;
    logic             w_pop;
    logic [PW-1:0]    w_head_nxt;
    logic [CW-1:0]    w_count_nxt;
    logic [WIDTH-1:0] w_head_data;
    logic             w_head_zero;

    // Bitwise operation datapath
    always_comb begin
        w_res = '0;
        case (op_e'(op))
            OP_AND:  w_res = in0 & in1;
            OP_OR:   w_res = in0 | in1;
            OP_XOR:  w_res = in0 ^ in1;
            OP_NOR:  w_res = ~(in0 | in1);
            OP_NAND: w_res = ~(in0 & in1);
            OP_XNOR: w_res = ~(in0 ^ in1);
            OP_ANDN: w_res = in0 & ~in1;
            OP_ORN:  w_res = in0 | ~in1;
            default: w_res = '0;
        endcase
    end

    assign w_res_zero = (w_res == '0);

    // Handshakes use only registered flags, so in_ready never sees out_ready
    assign w_push = in_valid & r_in_ready;
    assign w_pop  = r_out_valid & out_ready;

    // Next occupancy, next head pointer and the entry that will sit at the head
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end

        // DEPTH is a power of two, so PW-bit overflow is the modulo-DEPTH wrap
        w_head_nxt = w_pop ? (r_head + PW'(1)) : r_head;

        // With one entry left after a push, that entry is the one being pushed
        if (w_push && (w_count_nxt == CW'(1))) begin
            w_head_data = w_res;
            w_head_zero = w_res_zero;
        end else begin
            w_head_data = r_mem[w_head_nxt];
            w_head_zero = r_zmem[w_head_nxt];
        end
    end

    // Buffer state, pointers and registered handshake/output values
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_zero      <= 1'b1;
        end else begin
            if (w_push) begin
                r_mem[r_tail]  <= w_res;
                r_zmem[r_tail] <= w_res_zero;
                r_tail         <= r_tail + PW'(1);
            end
            r_head      <= w_head_nxt;
            r_count     <= w_count_nxt;
            r_in_ready  <= (w_count_nxt < CW'(DEPTH));
            r_out_valid <= (w_count_nxt != '0);
            // Output keeps its last value while the buffer is empty
            if (w_count_nxt != '0) begin
                r_out  <= w_head_data;
                r_zero <= w_head_zero;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign zero      = r_zero;
    assign count     = r_count;

endmodule
